// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA raster pipeline: default 1280x1024@60 timing
// (108 MHz pixel clock), colour/coordinate widths and the test-pattern mode
// encodings driven on MODE.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_pkg;

  // 1280x1024@60 horizontal timing, in pixel clocks
  localparam int VGA_H_ACTIVE = 1280;
  localparam int VGA_H_FP     = 48;
  localparam int VGA_H_SYNC   = 112;
  localparam int VGA_H_BP     = 248;

  // 1280x1024@60 vertical timing, in lines
  localparam int VGA_V_ACTIVE = 1024;
  localparam int VGA_V_FP     = 1;
  localparam int VGA_V_SYNC   = 3;
  localparam int VGA_V_BP     = 38;

  // Datapath widths
  localparam int VGA_COLOR_W  = 4;
  localparam int VGA_COORD_W  = 12;

  // Test-pattern mode encodings
  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_BARS = 2'd1;
  localparam logic [1:0] MODE_GRID = 2'd2;
  localparam logic [1:0] MODE_GREY = 2'd3;

endpackage

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
// Fixed-depth synchronous shift register with a synchronous reset value.
// Carries the timing bundle so it lines up with the drawing logic's colour.
// DEPTH=0 degenerates to a wire.
// Ports:
//   CLK      in   pixel clock
//   RESET    in   synchronous, active-high; loads every stage with RST_VAL
//   bundle   in   WIDTH-bit word entering the line
//   delayed  out  word that entered DEPTH clocks earlier
// -----------------------------------------------------------------------------
module vga_delay_line #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] bundle,
  output logic [WIDTH-1:0] delayed
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign delayed = bundle;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_r [DEPTH];

      // Shift the bundle one stage per clock; reset loads the idle value everywhere
      always_ff @(posedge CLK) begin
        if (RESET) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= RST_VAL;
          end
        end else begin
          stage_r[0] <= bundle;
          for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign delayed = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_pipe.sv
// -----------------------------------------------------------------------------
// vga_timing_pipe
// VGA raster generator and connector output stage. Issues pixel coordinates to
// the drawing logic, takes its colour PIX_LAT clocks later, and registers
// colour/blanking/syncs aligned at the connector. Offers test patterns
// selected frame-synchronously via MODE.
// Ports:
//   CLK          in   pixel clock
//   RESET        in   synchronous, active-high
//   MODE         in   0 pass-through, 1 colour bars, 2 grid, 3 mid-grey
//   PIX_RED/GREEN/BLUE in  drawing-logic colour for the coordinate issued
//                          PIX_LAT clocks earlier
//   HORZ_COORD   out  horizontal counter
//   VERT_COORD   out  vertical counter
//   ACTIVE       out  current coordinate is visible
//   LINE_START   out  pulse when HORZ_COORD==0
//   FRAME_START  out  pulse when HORZ_COORD==0 and VERT_COORD==0
//   VGA_RED/GREEN/BLUE out registered connector colour
//   VGA_HS/VGA_VS     out registered syncs, polarity set by HS_POL/VS_POL
// Connector outputs show coordinate (h,v) PIX_LAT+1 clocks after it is issued.
// -----------------------------------------------------------------------------
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int COLOR_W  = VGA_COLOR_W,
  parameter int COORD_W  = VGA_COORD_W,
  parameter int PIX_LAT  = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [1:0]         MODE,
  input  logic [COLOR_W-1:0] PIX_RED,
  input  logic [COLOR_W-1:0] PIX_GREEN,
  input  logic [COLOR_W-1:0] PIX_BLUE,
  output logic [COORD_W-1:0] HORZ_COORD,
  output logic [COORD_W-1:0] VERT_COORD,
  output logic               ACTIVE,
  output logic               LINE_START,
  output logic               FRAME_START,
  output logic [COLOR_W-1:0] VGA_RED,
  output logic [COLOR_W-1:0] VGA_GREEN,
  output logic [COLOR_W-1:0] VGA_BLUE,
  output logic               VGA_HS,
  output logic               VGA_VS
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_END  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_END  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START   = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END     = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START   = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END     = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] BAR_LAST   = COORD_W'(H_ACTIVE / 8 - 1);
  localparam logic [COORD_W-1:0] GRID_MASK  = COORD_W'(63);
  localparam logic [COORD_W-1:0] COORD_ONE  = COORD_W'(1);
  localparam logic [COLOR_W-1:0] GREY_LEVEL = {1'b1, {(COLOR_W-1){1'b0}}};

  // Bundle layout: {active, hs, vs, mode, v, h}; hs/vs are logical (1 = in sync)
  localparam int BUNDLE_W = 3 + 2 + 2 * COORD_W;

  logic [COORD_W-1:0]  h_r;
  logic [COORD_W-1:0]  v_r;
  logic [1:0]          mode_r;
  logic [1:0]          cur_mode_s;
  logic                active_s;
  logic                hs_s;
  logic                vs_s;
  logic                frame_start_s;
  logic [BUNDLE_W-1:0] bundle_s;
  logic [BUNDLE_W-1:0] delayed_s;

  logic                d_active_s;
  logic                d_hs_s;
  logic                d_vs_s;
  logic [1:0]          d_mode_s;
  logic [COORD_W-1:0]  d_h_s;
  logic [COORD_W-1:0]  d_v_s;

  logic [2:0]          bar_r;
  logic [COORD_W-1:0]  seg_r;
  logic [2:0]          cur_bar_s;
  logic [COORD_W-1:0]  cur_seg_s;
  logic                grid_s;

  logic [COLOR_W-1:0]  src_red_s;
  logic [COLOR_W-1:0]  src_green_s;
  logic [COLOR_W-1:0]  src_blue_s;
  logic [COLOR_W-1:0]  red_r;
  logic [COLOR_W-1:0]  green_r;
  logic [COLOR_W-1:0]  blue_r;
  logic                hs_r;
  logic                vs_r;

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------

  // Horizontal/vertical position; reset wins over counting and aborts the frame
  always_ff @(posedge CLK) begin
    if (RESET) begin
      h_r <= '0;
      v_r <= '0;
    end else if (h_r == H_LAST) begin
      h_r <= '0;
      if (v_r == V_LAST) begin
        v_r <= '0;
      end else begin
        v_r <= v_r + COORD_ONE;
      end
    end else begin
      h_r <= h_r + COORD_ONE;
      v_r <= v_r;
    end
  end

  assign active_s      = (h_r < H_ACT_END) && (v_r < V_ACT_END);
  assign hs_s          = (h_r >= HS_START) && (h_r < HS_END);
  assign vs_s          = (v_r >= VS_START) && (v_r < VS_END);
  assign frame_start_s = (h_r == '0) && (v_r == '0);

  assign HORZ_COORD  = h_r;
  assign VERT_COORD  = v_r;
  assign ACTIVE      = active_s;
  assign LINE_START  = (h_r == '0);
  assign FRAME_START = frame_start_s;

  // ---------------------------------------------------------------------------
  // Frame-synchronous mode selection
  // ---------------------------------------------------------------------------

  // Pixel (0,0) already uses the freshly sampled MODE, so the whole frame
  // (including the first pixels still in flight) shares one mode.
  assign cur_mode_s = frame_start_s ? MODE : mode_r;

  // Hold the mode for the rest of the frame once sampled at frame start
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mode_r <= MODE_PASS;
    end else if (frame_start_s) begin
      mode_r <= MODE;
    end else begin
      mode_r <= mode_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Alignment with the drawing logic's latency
  // ---------------------------------------------------------------------------

  assign bundle_s = {active_s, hs_s, vs_s, cur_mode_s, v_r, h_r};

  vga_delay_line #(
    .WIDTH   (BUNDLE_W),
    .DEPTH   (PIX_LAT),
    .RST_VAL ({BUNDLE_W{1'b0}})
  ) u_delay (
    .CLK     (CLK),
    .RESET   (RESET),
    .bundle  (bundle_s),
    .delayed (delayed_s)
  );

  assign {d_active_s, d_hs_s, d_vs_s, d_mode_s, d_v_s, d_h_s} = delayed_s;

  // ---------------------------------------------------------------------------
  // Colour-bar segment tracking on the delayed coordinate
  // ---------------------------------------------------------------------------

  // A new line restarts at bar 0; otherwise continue from the tracked state
  always_comb begin
    cur_bar_s = bar_r;
    cur_seg_s = seg_r;
    if (d_h_s == '0) begin
      cur_bar_s = 3'd0;
      cur_seg_s = '0;
    end else begin
      cur_bar_s = bar_r;
      cur_seg_s = seg_r;
    end
  end

  // Step through H_ACTIVE/8-pixel bars without a divider; bars past 7 only
  // occur in blanking, where colour is forced to zero anyway.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bar_r <= 3'd0;
      seg_r <= '0;
    end else if (cur_seg_s == BAR_LAST) begin
      bar_r <= cur_bar_s + 3'd1;
      seg_r <= '0;
    end else begin
      bar_r <= cur_bar_s;
      seg_r <= cur_seg_s + COORD_ONE;
    end
  end

  // Grid lines every 64 pixels/lines; masking keeps the full coordinate in use
  assign grid_s = ((d_h_s & GRID_MASK) == '0) || ((d_v_s & GRID_MASK) == '0);

  // ---------------------------------------------------------------------------
  // Pattern source and connector register
  // ---------------------------------------------------------------------------

  // Pick the colour source for the delayed coordinate's mode
  always_comb begin
    src_red_s   = '0;
    src_green_s = '0;
    src_blue_s  = '0;
    case (d_mode_s)
      MODE_PASS: begin
        src_red_s   = PIX_RED;
        src_green_s = PIX_GREEN;
        src_blue_s  = PIX_BLUE;
      end
      MODE_BARS: begin
        src_red_s   = {COLOR_W{cur_bar_s[2]}};
        src_green_s = {COLOR_W{cur_bar_s[1]}};
        src_blue_s  = {COLOR_W{cur_bar_s[0]}};
      end
      MODE_GRID: begin
        if (grid_s) begin
          src_red_s   = '1;
          src_green_s = '1;
          src_blue_s  = '1;
        end else begin
          src_red_s   = '0;
          src_green_s = '0;
          src_blue_s  = '0;
        end
      end
      MODE_GREY: begin
        src_red_s   = GREY_LEVEL;
        src_green_s = GREY_LEVEL;
        src_blue_s  = GREY_LEVEL;
      end
      default: begin
        src_red_s   = '0;
        src_green_s = '0;
        src_blue_s  = '0;
      end
    endcase
  end

  // Register blanked colour and polarity-adjusted syncs for the connector
  always_ff @(posedge CLK) begin
    if (RESET) begin
      red_r   <= '0;
      green_r <= '0;
      blue_r  <= '0;
      hs_r    <= ~HS_POL;
      vs_r    <= ~VS_POL;
    end else begin
      if (d_active_s) begin
        red_r   <= src_red_s;
        green_r <= src_green_s;
        blue_r  <= src_blue_s;
      end else begin
        red_r   <= '0;
        green_r <= '0;
        blue_r  <= '0;
      end
      hs_r <= d_hs_s ? HS_POL : ~HS_POL;
      vs_r <= d_vs_s ? VS_POL : ~VS_POL;
    end
  end

  assign VGA_RED   = red_r;
  assign VGA_GREEN = green_r;
  assign VGA_BLUE  = blue_r;
  assign VGA_HS    = hs_r;
  assign VGA_VS    = vs_r;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_pipe
// Directed bench for vga_timing_pipe on a small 24x12 raster (16x8 visible,
// PIX_LAT=2). A second instance with inverted sync polarity shares all inputs.
// Expected values are hand-derived from the raster timing.
// -----------------------------------------------------------------------------
module tb_vga_timing_pipe;

  localparam int COLOR_W = 4;
  localparam int COORD_W = 12;

  logic               CLK;
  logic               RESET;
  logic [1:0]         MODE;
  logic [COLOR_W-1:0] PIX_RED;
  logic [COLOR_W-1:0] PIX_GREEN;
  logic [COLOR_W-1:0] PIX_BLUE;

  logic [COORD_W-1:0] HORZ_COORD, VERT_COORD;
  logic               ACTIVE, LINE_START, FRAME_START;
  logic [COLOR_W-1:0] VGA_RED, VGA_GREEN, VGA_BLUE;
  logic               VGA_HS, VGA_VS;

  logic [COORD_W-1:0] horz_n, vert_n;
  logic               active_n, line_start_n, frame_start_n;
  logic [COLOR_W-1:0] red_n, green_n, blue_n;
  logic               hs_n, vs_n;

  int errors = 0;
  int checks = 0;

  // Drawing-logic model: colour for the coordinate issued two clocks earlier
  logic [COORD_W-1:0] pix_d1, pix_d2;
  always @(posedge CLK) begin
    pix_d1 <= HORZ_COORD;
    pix_d2 <= pix_d1;
  end
  assign PIX_RED   = pix_d2[3:0];
  assign PIX_GREEN = 4'hA;
  assign PIX_BLUE  = 4'h5;

  vga_timing_pipe #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .COLOR_W(COLOR_W), .COORD_W(COORD_W), .PIX_LAT(2)
  ) u_dut (
    .CLK(CLK), .RESET(RESET), .MODE(MODE),
    .PIX_RED(PIX_RED), .PIX_GREEN(PIX_GREEN), .PIX_BLUE(PIX_BLUE),
    .HORZ_COORD(HORZ_COORD), .VERT_COORD(VERT_COORD), .ACTIVE(ACTIVE),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START),
    .VGA_RED(VGA_RED), .VGA_GREEN(VGA_GREEN), .VGA_BLUE(VGA_BLUE),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS)
  );

  vga_timing_pipe #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .COLOR_W(COLOR_W), .COORD_W(COORD_W), .PIX_LAT(2)
  ) u_dut_neg (
    .CLK(CLK), .RESET(RESET), .MODE(MODE),
    .PIX_RED(PIX_RED), .PIX_GREEN(PIX_GREEN), .PIX_BLUE(PIX_BLUE),
    .HORZ_COORD(horz_n), .VERT_COORD(vert_n), .ACTIVE(active_n),
    .LINE_START(line_start_n), .FRAME_START(frame_start_n),
    .VGA_RED(red_n), .VGA_GREEN(green_n), .VGA_BLUE(blue_n),
    .VGA_HS(hs_n), .VGA_VS(vs_n)
  );

  // 10 ns pixel clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Absolute time limit in case a wait misbehaves
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_coord(input int h, input int v, input string tag);
    int n;
    n = 0;
    while (!(HORZ_COORD == COORD_W'(h) && VERT_COORD == COORD_W'(v)) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL %s: coordinate (%0d,%0d) not reached in %0d cycles", tag, h, v, n);
    end
  endtask

  // Wait for (h,v) to be issued, then check the connector PIX_LAT+1 clocks later
  task automatic expect_pix(input int h, input int v, input logic [3:0] r,
                            input logic [3:0] g, input logic [3:0] b, input string tag);
    wait_coord(h, v, tag);
    repeat (3) tick();
    check({tag, "_red"},   VGA_RED,   r);
    check({tag, "_green"}, VGA_GREEN, g);
    check({tag, "_blue"},  VGA_BLUE,  b);
  endtask

  logic [3:0] bar_red   [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF};
  logic [3:0] bar_green [8] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF};
  logic [3:0] bar_blue  [8] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF};

  initial begin
    int line_cnt;
    int frame_cnt;
    RESET = 1'b1;
    MODE  = 2'd0;
    repeat (3) tick();

    // Reset state
    check("rst_horz", HORZ_COORD, 0);
    check("rst_vert", VERT_COORD, 0);
    check("rst_red",  VGA_RED, 0);
    check("rst_hs",   VGA_HS, 0);
    check("rst_vs",   VGA_VS, 0);
    check("rst_hs_n", hs_n, 1);
    check("rst_vs_n", vs_n, 1);

    // 1. Raster counting after release
    RESET = 1'b0;
    #1;
    check("rel_frame_start", FRAME_START, 1);
    check("rel_horz", HORZ_COORD, 0);
    line_cnt  = 0;
    frame_cnt = 0;
    for (int i = 1; i <= 288; i++) begin
      tick();
      if (LINE_START)  line_cnt++;
      if (FRAME_START) frame_cnt++;
      if (i == 23)  check("h_last", HORZ_COORD, 23);
      if (i == 24) begin
        check("h_wrap", HORZ_COORD, 0);
        check("v_step", VERT_COORD, 1);
        check("line_start", LINE_START, 1);
      end
      if (i == 287) begin
        check("v_last", VERT_COORD, 11);
        check("h_last_frame", HORZ_COORD, 23);
      end
      if (i == 288) begin
        check("v_wrap", VERT_COORD, 0);
        check("frame_start_288", FRAME_START, 1);
      end
    end
    check("line_count", line_cnt, 12);
    check("frame_count", frame_cnt, 1);

    // 2. Horizontal sync: 3 clocks wide, starting 3 clocks after h==18
    wait_coord(18, 0, "hs_wait");
    tick();
    for (int k = 2; k <= 6; k++) begin
      tick();
      check($sformatf("hs_off%0d", k),   VGA_HS, (k >= 3 && k <= 5) ? 1 : 0);
      check($sformatf("hs_n_off%0d", k), hs_n,   (k >= 3 && k <= 5) ? 0 : 1);
    end
    // Vertical sync on lines 9-10 only
    wait_coord(23, 8, "vs_wait_a");
    repeat (3) tick();
    check("vs_line8", VGA_VS, 0);
    check("vs_n_line8", vs_n, 1);
    tick();
    check("vs_line9", VGA_VS, 1);
    check("vs_n_line9", vs_n, 0);
    wait_coord(23, 10, "vs_wait_b");
    repeat (3) tick();
    check("vs_line10", VGA_VS, 1);
    tick();
    check("vs_line11", VGA_VS, 0);

    // 3. Pass-through, no pixel shift
    expect_pix(0, 1,  4'h0, 4'hA, 4'h5, "pass_h0");
    expect_pix(7, 1,  4'h7, 4'hA, 4'h5, "pass_h7");
    expect_pix(15, 1, 4'hF, 4'hA, 4'h5, "pass_h15");
    expect_pix(17, 1, 4'h0, 4'h0, 4'h0, "pass_hblank");
    expect_pix(3, 8,  4'h0, 4'h0, 4'h0, "pass_vblank");

    // 4. Mid-frame mode change waits for the next frame
    wait_coord(5, 3, "mode_wait");
    MODE = 2'd1;
    expect_pix(10, 3, 4'hA, 4'hA, 4'h5, "switch_same_frame");
    expect_pix(15, 7, 4'hF, 4'hA, 4'h5, "switch_last_pix");
    wait_coord(0, 0, "bars_wait");
    repeat (3) tick();
    for (int h = 0; h < 16; h++) begin
      check($sformatf("bars_red_h%0d", h),   VGA_RED,   bar_red[h/2]);
      check($sformatf("bars_green_h%0d", h), VGA_GREEN, bar_green[h/2]);
      check($sformatf("bars_blue_h%0d", h),  VGA_BLUE,  bar_blue[h/2]);
      tick();
    end
    check("bars_blank_red", VGA_RED, 0);
    check("bars_blank_blue", VGA_BLUE, 0);

    // 5. Grid
    MODE = 2'd2;
    wait_coord(0, 0, "grid_wait");
    repeat (3) tick();
    for (int h = 0; h < 16; h++) begin
      check($sformatf("grid_v0_red_h%0d", h),  VGA_RED,  4'hF);
      check($sformatf("grid_v0_blue_h%0d", h), VGA_BLUE, 4'hF);
      tick();
    end
    check("grid_blank", VGA_RED, 0);
    expect_pix(1, 1, 4'h0, 4'h0, 4'h0, "grid_h1v1");
    expect_pix(5, 1, 4'h0, 4'h0, 4'h0, "grid_h5v1");
    expect_pix(0, 2, 4'hF, 4'hF, 4'hF, "grid_h0v2");
    expect_pix(0, 7, 4'hF, 4'hF, 4'hF, "grid_h0v7");
    expect_pix(0, 8, 4'h0, 4'h0, 4'h0, "grid_vblank");

    // 6. Reset mid-frame while mid-grey is active
    MODE = 2'd3;
    wait_coord(0, 0, "grey_wait");
    expect_pix(2, 0, 4'h8, 4'h8, 4'h8, "grey_h2");
    wait_coord(10, 5, "rst_mid_wait");
    check("grey_before_rst", VGA_RED, 4'h8);
    RESET = 1'b1;
    tick();
    check("mid_rst_red",   VGA_RED, 0);
    check("mid_rst_green", VGA_GREEN, 0);
    check("mid_rst_blue",  VGA_BLUE, 0);
    check("mid_rst_hs",    VGA_HS, 0);
    check("mid_rst_vs",    VGA_VS, 0);
    check("mid_rst_hs_n",  hs_n, 1);
    check("mid_rst_vs_n",  vs_n, 1);
    check("mid_rst_horz",  HORZ_COORD, 0);
    check("mid_rst_vert",  VERT_COORD, 0);
    MODE = 2'd0;
    tick();
    RESET = 1'b0;
    #1;
    check("rerel_frame_start", FRAME_START, 1);
    tick();
    check("rerel_horz", HORZ_COORD, 1);
    check("rerel_red_flushed", VGA_RED, 0);
    check("rerel_hs", VGA_HS, 0);
    expect_pix(4, 0, 4'h4, 4'hA, 4'h5, "rerel_pass_h4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
